// File: rtl/stream_filter_ctrl.sv
// stream_filter_ctrl: frame-sequencing controller in front of stream_video_filter.
// Locks onto start-of-frame, forwards only frames that begin with a SOF, bounds every
// line to MAX_IMG_RES pixels (forcing tlast and dropping the tail), measures frame
// geometry and flags short/long lines to software.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cfg_enable                  1 = forward frames (sampled on each accepted SOF)
//   s_axis_video_*              upstream AXI4-Stream video (tuser = SOF, tlast = EOL)
//   m_axis_video_*              downstream to the filter, one register slice
//   frame_width, frame_height   geometry of the last completed frame
//   frame_done                  one-cycle pulse when geometry updates
//   err_early_eol, err_late_eol sticky line-structure errors, cleared by err_clr
//   busy                        high while inside a frame (ACTIVE or TRUNC)
module stream_filter_ctrl #(
  parameter int unsigned MAX_IMG_RES = 1920,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic [23:0]      s_axis_video_tdata,
  input  logic             s_axis_video_tvalid,
  output logic             s_axis_video_tready,
  input  logic             s_axis_video_tuser,
  input  logic             s_axis_video_tlast,
  output logic [23:0]      m_axis_video_tdata,
  output logic             m_axis_video_tvalid,
  input  logic             m_axis_video_tready,
  output logic             m_axis_video_tuser,
  output logic             m_axis_video_tlast,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic             frame_done,
  output logic             err_early_eol,
  output logic             err_late_eol,
  input  logic             err_clr,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MaxRes = CNT_W'(MAX_IMG_RES);

  typedef enum logic [1:0] {StIdle, StSync, StActive, StTrunc} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] width_q, width_d;

  logic             accept;
  logic             do_beat;
  logic [CNT_W-1:0] base_col;
  logic [CNT_W-1:0] base_row;
  logic [CNT_W-1:0] next_col;
  logic             fwd;
  logic             last_out;
  logic             set_early;
  logic             set_late;
  logic             done_d;

  // The slice can take a beat whenever it is empty or draining; held low in reset.
  assign s_axis_video_tready = !reset && (!m_axis_video_tvalid || m_axis_video_tready);
  assign accept = s_axis_video_tvalid && s_axis_video_tready;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    width_d   = width_q;
    do_beat   = 1'b0;
    base_col  = col_q;
    base_row  = row_q;
    next_col  = '0;
    fwd       = 1'b0;
    last_out  = 1'b0;
    set_early = 1'b0;
    set_late  = 1'b0;
    done_d    = 1'b0;

    if (state_q == StIdle && cfg_enable) begin
      state_d = StSync;
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
        end
        StSync: begin
          if (s_axis_video_tuser) begin
            if (cfg_enable) begin
              do_beat  = 1'b1;
              base_col = '0;
              base_row = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StActive, StTrunc: begin
          if (s_axis_video_tuser) begin
            // SOF closes the previous frame, even if it arrives mid-line.
            done_d = 1'b1;
            if (col_q != '0) set_early = 1'b1;
            if (cfg_enable) begin
              do_beat  = 1'b1;
              base_col = '0;
              base_row = '0;
            end else begin
              state_d = StIdle;
            end
          end else if (state_q == StTrunc) begin
            if (s_axis_video_tlast) begin
              state_d = StActive;
              col_d   = '0;
            end
          end else begin
            do_beat = 1'b1;
          end
        end
      endcase
    end

    if (do_beat) begin
      fwd      = 1'b1;
      next_col = base_col + 1'b1;
      if (s_axis_video_tlast) begin
        last_out = 1'b1;
        if (base_row == '0) begin
          width_d = next_col;
        end else if (next_col < width_q) begin
          set_early = 1'b1;
        end
        row_d   = base_row + 1'b1;
        col_d   = '0;
        state_d = StActive;
      end else if (next_col == MaxRes || (base_row != '0 && next_col == width_q)) begin
        // Cut the line here; the rest up to the real tlast is dropped in TRUNC.
        last_out = 1'b1;
        set_late = 1'b1;
        if (base_row == '0) width_d = next_col;
        row_d   = base_row + 1'b1;
        col_d   = '0;
        state_d = StTrunc;
      end else begin
        col_d   = next_col;
        row_d   = base_row;
        state_d = StActive;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= StIdle;
      col_q               <= '0;
      row_q               <= '0;
      width_q             <= '0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      frame_width         <= '0;
      frame_height        <= '0;
      frame_done          <= 1'b0;
      err_early_eol       <= 1'b0;
      err_late_eol        <= 1'b0;
      busy                <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      width_q <= width_d;
      if (s_axis_video_tready) begin
        m_axis_video_tvalid <= fwd;
      end
      if (fwd) begin
        m_axis_video_tdata <= s_axis_video_tdata;
        m_axis_video_tuser <= s_axis_video_tuser;
        m_axis_video_tlast <= last_out;
      end
      if (done_d) begin
        frame_width  <= width_q;
        frame_height <= row_q;
      end
      frame_done    <= done_d;
      // Clear has priority over a set in the same cycle.
      err_early_eol <= err_clr ? 1'b0 : (err_early_eol | set_early);
      err_late_eol  <= err_clr ? 1'b0 : (err_late_eol | set_late);
      busy          <= (state_d == StActive) || (state_d == StTrunc);
    end
  end

endmodule

// File: tb/tb_stream_filter_ctrl.sv
// Directed bench for stream_filter_ctrl with MAX_IMG_RES = 8.
module tb_stream_filter_ctrl;

  localparam int unsigned MaxRes = 8;
  localparam int unsigned CntW   = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_enable = 1'b0;
  logic            err_clr = 1'b0;
  logic [23:0]     s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tuser = 1'b0;
  logic            s_tlast = 1'b0;
  logic            s_tready;
  logic [23:0]     m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tuser;
  logic            m_tlast;
  logic [CntW-1:0] frame_width;
  logic [CntW-1:0] frame_height;
  logic            frame_done;
  logic            err_early_eol;
  logic            err_late_eol;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int pix = 1;
  int done_cnt = 0;
  logic [CntW-1:0] done_w = '0;
  logic [CntW-1:0] done_h = '0;
  bit toggle = 1'b0;
  logic [25:0] out_q[$];
  logic [25:0] exp_q[$];

  stream_filter_ctrl #(
    .MAX_IMG_RES(MaxRes),
    .CNT_W      (CntW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_enable         (cfg_enable),
    .s_axis_video_tdata (s_tdata),
    .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready),
    .s_axis_video_tuser (s_tuser),
    .s_axis_video_tlast (s_tlast),
    .m_axis_video_tdata (m_tdata),
    .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready),
    .m_axis_video_tuser (m_tuser),
    .m_axis_video_tlast (m_tlast),
    .frame_width        (frame_width),
    .frame_height       (frame_height),
    .frame_done         (frame_done),
    .err_early_eol      (err_early_eol),
    .err_late_eol       (err_late_eol),
    .err_clr            (err_clr),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes complete on the posedge following a negedge where valid && ready.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (m_tvalid && m_tready) out_q.push_back({m_tuser, m_tlast, m_tdata});
      if (frame_done) begin
        done_cnt++;
        done_w = frame_width;
        done_h = frame_height;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (toggle) m_tready = ~m_tready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One input beat; fwd/el give whether it must appear downstream and its output tlast.
  task automatic beat(input logic u, input logic l, input bit fwd, input logic el);
    int n;
    s_tvalid = 1'b1;
    s_tuser  = u;
    s_tlast  = l;
    s_tdata  = 24'(pix);
    if (fwd) exp_q.push_back({u, el, 24'(pix)});
    pix++;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hs_ready", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic line_px(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, (i == n - 1), 1'b1, (i == n - 1));
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_cnt"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_done(input string tag, input int cnt, input int w, input int h);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(cnt));
    check({tag, "_width"}, 32'(done_w), 32'(w));
    check({tag, "_height"}, 32'(done_h), 32'(h));
  endtask

  initial begin
    #3 reset = 1'b1;
    idle(3);
    check("rst_m_valid", 32'(m_tvalid), 0);
    check("rst_m_data", 32'(m_tdata), 0);
    check("rst_m_user_last", 32'({m_tuser, m_tlast}), 0);
    check("rst_s_ready", 32'(s_tready), 0);
    check("rst_frame_w", 32'(frame_width), 0);
    check("rst_frame_h", 32'(frame_height), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_errs", 32'({err_early_eol, err_late_eol}), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    idle(1);

    // 5 beats before SOF dropped, 4x3 frame, then next SOF.
    cfg_enable = 1'b1;
    idle(2);
    repeat (5) beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    check("lat_valid", 32'(m_tvalid), 1);
    check("lat_sof", 32'(m_tuser), 1);
    line_px(3);
    line_px(4);
    line_px(4);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    compare_out("a");
    check_done("a", 1, 4, 3);
    check("a_errs", 32'({err_early_eol, err_late_eol}), 0);
    check("a_busy", 32'(busy), 1);

    // Short second line.
    line_px(3);
    line_px(2);
    check("b_early", 32'(err_early_eol), 1);
    line_px(4);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    compare_out("b");
    check_done("b", 2, 4, 3);
    check("b_late", 32'(err_late_eol), 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("b_clr", 32'(err_early_eol), 0);

    // First line of 11 pixels truncated at 8.
    for (int i = 0; i < 10; i++) begin
      if (i < 6) beat(1'b0, 1'b0, 1'b1, 1'b0);
      else if (i == 6) beat(1'b0, 1'b0, 1'b1, 1'b1);
      else beat(1'b0, (i == 9), 1'b0, 1'b0);
    end
    check("c_late", 32'(err_late_eol), 1);
    check("c_early", 32'(err_early_eol), 0);
    line_px(8);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    compare_out("c");
    check_done("c", 3, 8, 2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;

    // Downstream ready toggling.
    toggle = 1'b1;
    line_px(3);
    line_px(4);
    toggle = 1'b0;
    @(posedge clk);
    #2;
    m_tready = 1'b1;
    idle(4);
    compare_out("d");
    check("d_errs", 32'({err_early_eol, err_late_eol}), 0);

    // Reset on the 6th beat of a frame.
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) beat(1'b0, 1'b0, 1'b1, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 24'hABCDEF;
    reset    = 1'b1;
    #1;
    check("e_rst_m_valid", 32'(m_tvalid), 0);
    check("e_rst_s_ready", 32'(s_tready), 0);
    check("e_rst_busy", 32'(busy), 0);
    check("e_rst_frame_w", 32'(frame_width), 0);
    check("e_rst_frame_h", 32'(frame_height), 0);
    s_tvalid = 1'b0;
    out_q.delete();
    exp_q.delete();
    idle(2);
    reset = 1'b0;
    idle(2);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    line_px(2);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    compare_out("e");
    check_done("e", 5, 2, 2);
    check("e_frame_w", 32'(frame_width), 2);

    // cfg_enable dropped mid-frame.
    cfg_enable = 1'b0;
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    line_px(2);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    compare_out("f");
    check_done("f", 6, 2, 2);
    check("f_busy", 32'(busy), 0);
    check("f_s_ready", 32'(s_tready), 1);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    compare_out("f2");

    // 1-pixel lines (SOF and EOL on the same beat).
    cfg_enable = 1'b1;
    idle(2);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    compare_out("g");
    check_done("g", 7, 1, 2);

    // Set and clear in the same cycle leaves the flag clear.
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    err_clr = 1'b1;
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    err_clr = 1'b0;
    check("h_clr_wins", 32'(err_early_eol), 0);
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    check("h_early_set", 32'(err_early_eol), 1);
    idle(4);
    compare_out("h");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
